booth_seq_mult: RTL and testbench
=================================

# booth_seq_mult

Sequential signed multiplier using Booth recoding, parametrised in operand width and recoding radix. It takes two N-bit two's-complement operands through a start/done handshake and returns the exact 2N-bit product after a fixed number of cycles. It is the clocked successor to the team's combinational Booth multiplier, for arithmetic datapaths that share one multiplier across operations.

## Interface
- N, default 8: operand width in bits; must be even and at least 4.
- RADIX4, default 0: 0 selects radix-2 Booth (one bit per step); 1 selects radix-4 modified Booth (two bits per step).
- clk, input, 1: single clock; all state updates on the rising edge.
- rst, input, 1: asynchronous, active-high reset.
- start, input, 1: request a new multiply; sampled only in IDLE.
- X, input, N: signed multiplier; sampled on the accepting edge.
- Y, input, N: signed multiplicand; sampled on the accepting edge.
- busy, output, 1: high while an operation is in progress.
- done, output, 1: one-cycle pulse; Z is valid and new in this cycle.
- Z, output, 2N: signed product; holds the last result until the next done.

## Operation
- States: IDLE, RUN.
  - IDLE: if start=1, go to RUN.
  - RUN: go to IDLE after the final step.
- Load, on the accepting edge:
  - Register X into the multiplier shift register, with an appended bit E=0 below its LSB.
  - Register Y into the multiplicand register.
  - Clear the accumulator.
  - Load the step counter with K, where K=N for radix-2 and K=N/2 for radix-4.
- Radix-2 step: examine the pair {X[0],E}.
  - 10 adds −Y to the accumulator; 01 adds +Y; 00 and 11 add nothing.
  - Then arithmetic-shift {acc, X, E} right by 1.
- Radix-4 step: examine the triplet {X[1],X[0],E}.
  - The digit set is {0, ±Y, ±2Y}.
  - Then arithmetic-shift {acc, X, E} right by 2.
- Width rule:
  - The accumulator is N+2 bits and Y is sign-extended, so that −Y and ±2Y never overflow.
  - The case Y = −2^(N−1) must give the exact result with no special-case negation.
- All additions are two's complement. The final product is the low 2N bits of the concatenation {acc, X}, and is exact for every operand pair.
- Ignored requests:
  - start while busy=1 is ignored; the operation in flight is not disturbed.
  - X and Y may change freely after acceptance.
- Reset, asynchronous and allowed at any time, including mid-operation:
  - state goes to IDLE, and busy, done, counter, accumulator and Z all go to 0.
  - A partial result is never presented.

## Timing
- Accepting edge e0: the edge on which start=1 is seen in IDLE. busy=1 from e0.
- One Booth step per edge from e1 to eK.
- Completion at edge eK:
  - Z is registered.
  - done=1 for exactly one cycle (the cycle after eK).
  - busy=0 in that same cycle, and state is IDLE.
- Latency from the accepting edge to done: K+1 clocks.
  - This is 9 for N=8 radix-2, and 5 for N=8 radix-4.
- Back-to-back operation: start=1 during the done cycle is accepted on the next edge. Sustained throughput is one result every K+1 cycles.
- done and busy are never both high.
- Reset values: busy=0, done=0, Z=0.

## Structure
- Shared package booth_pkg holds:
  - the state enumeration (IDLE, RUN);
  - the radix constants RADIX2=0 and RADIX4=1;
  - a function giving step count K(N, RADIX4).
- Sub-module booth_recode: combinational, and parametrised by N and RADIX4.
  - Input: the low multiplier bits plus E, and the sign-extended Y.
  - Output: the N+2-bit addend.
  - It is shared by both radices.
- The top level holds the FSM, the counter, the shift registers and the output register.

## Test plan
- N=8, radix-2, X=7, Y=−3 → Z=−21 (0xFFEB); done pulses exactly 9 cycles after acceptance, one cycle wide.
- N=8, radix-2, X=−128, Y=−128 → Z=16384 (0x4000). Then X=5, Y=−128 → Z=−640.
- N=8, radix-4, X=−128, Y=127 → Z=−16256 (0xC080) after 5 cycles. Then X=127, Y=127 → Z=16129.
- Acceptance rules:
  - Pulse start again in the 3rd cycle of RUN with different X and Y: the first result is unchanged and the second start is ignored.
  - start=1 held through the done cycle: a second operation begins, and its done arrives K+1 cycles later.
- Assert rst in mid-RUN: busy, done and Z read 0 immediately (asynchronously). The next operation with X=−1, Y=−1 → Z=1.
- Exhaustive check for N=4 in both radices (all 256 operand pairs) against a reference model. Random checks for N=16 radix-4, including −32768 operands.

Source files
------------

// File: rtl/booth_pkg.sv
// Shared definitions for the sequential Booth multiplier: FSM states,
// radix selectors and the step-count helper.
package booth_pkg;

  typedef enum logic {IDLE, RUN} state_t;

  localparam int RADIX2 = 0;
  localparam int RADIX4 = 1;

  function automatic int step_count(input int n, input int radix4);
    return (radix4 == RADIX4) ? n / 2 : n;
  endfunction

endpackage

// File: rtl/booth_recode.sv
// Booth digit recoder: turns the low multiplier bits plus the appended bit E
// into the signed addend applied to the accumulator on one step.
module booth_recode
  import booth_pkg::*;
#(
  parameter int N      = 8,
  parameter int RADIX4 = 0
) (
  input  logic [2:0]   bits,
  input  logic [N+1:0] ys,
  output logic [N+1:0] addend
);

  logic [N+1:0] neg_y;
  logic [N+1:0] two_y;
  logic [N+1:0] neg_two_y;

  // Y arrives already sign-extended by two bits, so -Y and +-2Y cannot overflow.
  assign neg_y     = ~ys + (N+2)'(1);
  assign two_y     = ys << 1;
  assign neg_two_y = neg_y << 1;

  always_comb begin
    addend = '0;
    if (RADIX4 != RADIX2) begin
      case (bits)
        3'b001, 3'b010: addend = ys;
        3'b011:         addend = two_y;
        3'b100:         addend = neg_two_y;
        3'b101, 3'b110: addend = neg_y;
        default:        addend = '0;
      endcase
    end else begin
      case (bits[1:0])
        2'b01:   addend = ys;
        2'b10:   addend = neg_y;
        default: addend = '0;
      endcase
    end
  end

endmodule

// File: rtl/booth_seq_mult.sv
// Sequential signed Booth multiplier (radix-2 or radix-4) with a start/done
// handshake; the product is registered on the final step.
module booth_seq_mult
  import booth_pkg::*;
#(
  parameter int N      = 8,
  parameter int RADIX4 = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           start,
  input  logic [N-1:0]   X,
  input  logic [N-1:0]   Y,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] Z
);

  localparam int K  = step_count(N, RADIX4);
  localparam int CW = $clog2(K + 1);
  localparam int SH = (RADIX4 != RADIX2) ? 2 : 1;

  state_t         state;
  logic [N+1:0]   acc;
  logic [N+1:0]   ys;
  logic [N+1:0]   addend;
  logic [N+1:0]   sum;
  logic [N-1:0]   xr;
  logic           e;
  logic [CW-1:0]  cnt;
  logic [2*N+2:0] shifted;

  booth_recode #(.N(N), .RADIX4(RADIX4)) u_recode (
    .bits   ({xr[1:0], e}),
    .ys     (ys),
    .addend (addend)
  );

  // Add the recoded digit, then shift the whole {acc, X, E} chain arithmetically.
  assign sum     = acc + addend;
  assign shifted = $signed({sum, xr, e}) >>> SH;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
      cnt   <= '0;
      acc   <= '0;
      xr    <= '0;
      e     <= 1'b0;
      ys    <= '0;
      Z     <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state <= RUN;
            busy  <= 1'b1;
            acc   <= '0;
            xr    <= X;
            e     <= 1'b0;
            ys    <= {{2{Y[N-1]}}, Y};
            cnt   <= CW'(K);
          end
        end
        RUN: begin
          {acc, xr, e} <= shifted;
          cnt          <= cnt - CW'(1);
          // Last step: the product is the low 2N bits of {acc, X} after the shift.
          if (cnt == CW'(1)) begin
            state <= IDLE;
            busy  <= 1'b0;
            done  <= 1'b1;
            Z     <= shifted[2*N:1];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_seq_mult.sv
// Self-checking bench for booth_seq_mult: five instances (N=8 r2/r4, N=4 r2/r4,
// N=16 r4) checked against plain integer multiplication.
module tb_booth_seq_mult;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  start_vec;
  logic [15:0] x_bus;
  logic [15:0] y_bus;
  logic [4:0]  busy_vec;
  logic [4:0]  done_vec;
  logic [15:0] z0;
  logic [15:0] z1;
  logic [7:0]  z2;
  logic [7:0]  z3;
  logic [31:0] z4;
  logic signed [31:0] z_ext [5];

  int compared   = 0;
  int mismatched = 0;
  int widths [5] = '{8, 8, 4, 4, 16};
  int ks     [5] = '{8, 4, 4, 2, 8};

  always #5 clk = ~clk;

  booth_seq_mult #(.N(8), .RADIX4(0)) u_n8r2 (
    .clk(clk), .rst(rst), .start(start_vec[0]), .X(x_bus[7:0]), .Y(y_bus[7:0]),
    .busy(busy_vec[0]), .done(done_vec[0]), .Z(z0));
  booth_seq_mult #(.N(8), .RADIX4(1)) u_n8r4 (
    .clk(clk), .rst(rst), .start(start_vec[1]), .X(x_bus[7:0]), .Y(y_bus[7:0]),
    .busy(busy_vec[1]), .done(done_vec[1]), .Z(z1));
  booth_seq_mult #(.N(4), .RADIX4(0)) u_n4r2 (
    .clk(clk), .rst(rst), .start(start_vec[2]), .X(x_bus[3:0]), .Y(y_bus[3:0]),
    .busy(busy_vec[2]), .done(done_vec[2]), .Z(z2));
  booth_seq_mult #(.N(4), .RADIX4(1)) u_n4r4 (
    .clk(clk), .rst(rst), .start(start_vec[3]), .X(x_bus[3:0]), .Y(y_bus[3:0]),
    .busy(busy_vec[3]), .done(done_vec[3]), .Z(z3));
  booth_seq_mult #(.N(16), .RADIX4(1)) u_n16r4 (
    .clk(clk), .rst(rst), .start(start_vec[4]), .X(x_bus), .Y(y_bus),
    .busy(busy_vec[4]), .done(done_vec[4]), .Z(z4));

  assign z_ext[0] = {{16{z0[15]}}, z0};
  assign z_ext[1] = {{16{z1[15]}}, z1};
  assign z_ext[2] = {{24{z2[7]}}, z2};
  assign z_ext[3] = {{24{z3[7]}}, z3};
  assign z_ext[4] = z4;

  typedef struct {
    int     idx;
    int     a;
    int     b;
    longint expected;
  } vec_t;

  vec_t vecs[$];

  // Reference: sign-extend each operand from its width and multiply exactly.
  function automatic longint refProd(input int n, input int a, input int b);
    longint sa;
    longint sb;
    sa = longint'(a);
    sb = longint'(b);
    sa = (sa <<< (64 - n)) >>> (64 - n);
    sb = (sb <<< (64 - n)) >>> (64 - n);
    return sa * sb;
  endfunction

  task automatic checkOutput(input string name, input longint actual, input longint required);
    compared++;
    if (actual !== required) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, required);
    end
  endtask

  // Launch one multiply, scramble the operand buses after acceptance, and count
  // edges from the accepting edge (counted as 1) until done is seen.
  task automatic applyStimulus(input int idx, input logic [15:0] a, input logic [15:0] b,
                               output longint res, output int lat);
    @(negedge clk);
    x_bus = a;
    y_bus = b;
    start_vec[idx] = 1'b1;
    @(posedge clk);
    #1;
    lat = 1;
    start_vec[idx] = 1'b0;
    x_bus = 16'($urandom);
    y_bus = 16'($urandom);
    while (!done_vec[idx] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    res = longint'(z_ext[idx]);
  endtask

  initial begin
    longint res;
    int     lat;
    int     a;
    int     b;

    rst       = 1'b1;
    start_vec = '0;
    x_bus     = '0;
    y_bus     = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_busy", longint'(busy_vec), 0);
    checkOutput("reset_done", longint'(done_vec), 0);
    checkOutput("reset_z0", longint'(z_ext[0]), 0);
    checkOutput("reset_z4", longint'(z_ext[4]), 0);
    @(negedge clk);
    rst = 1'b0;

    vecs.push_back('{0, 7, -3, -21});
    vecs.push_back('{0, -128, -128, 16384});
    vecs.push_back('{0, 5, -128, -640});
    vecs.push_back('{1, -128, 127, -16256});
    vecs.push_back('{1, 127, 127, 16129});
    vecs.push_back('{1, -128, -128, 16384});
    vecs.push_back('{2, -8, -8, 64});
    vecs.push_back('{2, 7, -8, -56});
    vecs.push_back('{3, -8, 7, -56});
    vecs.push_back('{3, -8, -8, 64});
    vecs.push_back('{4, -32768, -32768, 64'sd1073741824});
    vecs.push_back('{4, -32768, 32767, -64'sd1073709056});
    vecs.push_back('{4, 12345, -321, -3962745});

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].idx, 16'(vecs[i].a), 16'(vecs[i].b), res, lat);
      checkOutput($sformatf("vec%0d_z", i), res, vecs[i].expected);
      checkOutput($sformatf("vec%0d_latency", i), lat, ks[vecs[i].idx] + 1);
      checkOutput($sformatf("vec%0d_busy_in_done", i), busy_vec[vecs[i].idx], 0);
      @(posedge clk);
      #1;
      checkOutput($sformatf("vec%0d_done_width", i), done_vec[vecs[i].idx], 0);
    end

    // A start pulse in the third RUN cycle must not disturb the operation in flight.
    @(negedge clk);
    x_bus = 16'(100);
    y_bus = 16'(-50);
    start_vec[0] = 1'b1;
    @(posedge clk);
    #1;
    start_vec[0] = 1'b0;
    lat = 1;
    repeat (2) begin
      @(posedge clk);
      #1;
      lat++;
    end
    x_bus = 16'(-7);
    y_bus = 16'(9);
    start_vec[0] = 1'b1;
    @(posedge clk);
    #1;
    lat++;
    start_vec[0] = 1'b0;
    while (!done_vec[0] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("ignored_start_z", longint'(z_ext[0]), -5000);
    checkOutput("ignored_start_latency", lat, 9);
    @(posedge clk);
    #1;
    checkOutput("ignored_start_idle", busy_vec[0], 0);

    // start held high through the done cycle chains a second operation.
    @(negedge clk);
    x_bus = 16'(3);
    y_bus = 16'(4);
    start_vec[1] = 1'b1;
    @(posedge clk);
    #1;
    x_bus = 16'(-5);
    y_bus = 16'(6);
    lat = 1;
    while (!done_vec[1] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("held_start_first_z", longint'(z_ext[1]), 12);
    checkOutput("held_start_busy_in_done", busy_vec[1], 0);
    @(posedge clk);
    #1;
    start_vec[1] = 1'b0;
    checkOutput("held_start_second_busy", busy_vec[1], 1);
    lat = 1;
    while (!done_vec[1] && lat < 40) begin
      @(posedge clk);
      #1;
      lat++;
    end
    checkOutput("held_start_second_z", longint'(z_ext[1]), -30);
    checkOutput("held_start_second_latency", lat, 5);

    // Asynchronous reset in the middle of RUN clears outputs before any clock edge.
    @(negedge clk);
    x_bus = 16'(100);
    y_bus = 16'(100);
    start_vec[0] = 1'b1;
    @(posedge clk);
    #1;
    start_vec[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    checkOutput("midrun_reset_busy", busy_vec[0], 0);
    checkOutput("midrun_reset_done", done_vec[0], 0);
    checkOutput("midrun_reset_z", longint'(z_ext[0]), 0);
    @(negedge clk);
    rst = 1'b0;
    applyStimulus(0, 16'hFFFF, 16'hFFFF, res, lat);
    checkOutput("after_reset_z", res, 1);
    checkOutput("after_reset_latency", lat, 9);

    // Exhaustive N=4 in both radices.
    for (int idx = 2; idx <= 3; idx++) begin
      for (int xa = 0; xa < 16; xa++) begin
        for (int yb = 0; yb < 16; yb++) begin
          applyStimulus(idx, 16'(xa), 16'(yb), res, lat);
          checkOutput($sformatf("n4_i%0d_%0d_%0d", idx, xa, yb), res, refProd(4, xa, yb));
        end
      end
    end

    // Random N=8 (both radices) and N=16 radix-4, biased toward the most negative value.
    for (int n = 0; n < 300; n++) begin
      int idx;
      idx = (n < 60) ? 0 : (n < 120) ? 1 : 4;
      a = int'($urandom_range(65535));
      b = int'($urandom_range(65535));
      if ($urandom_range(7) == 0) a = (widths[idx] == 16) ? 32768 : 128;
      if ($urandom_range(7) == 0) b = (widths[idx] == 16) ? 32768 : 128;
      applyStimulus(idx, 16'(a), 16'(b), res, lat);
      checkOutput($sformatf("rand_i%0d_%0d_%0d", idx, a, b), res, refProd(widths[idx], a, b));
      checkOutput($sformatf("rand_i%0d_latency", idx), lat, ks[idx] + 1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
